axi_mux_r: RTL and testbench

AXI_MUX_R -- requirements
Module: axi_mux_r

---
 rtl/axi_mux_r.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_mux_r.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mux_r.sv
// Read-channel mux: four AXI masters share one slave read port, one burst at a time.
// The slave R stream is buffered in a 2-entry FIFO and steered to the owning master.
module axi_mux_r #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          s0_rgrnt,
    input  logic          s1_rgrnt,
    input  logic          s2_rgrnt,
    input  logic          s3_rgrnt,
    input  logic          s0_ARVALID,
    input  logic [AW-1:0] s0_ARADDR,
    input  logic [7:0]    s0_ARLEN,
    output logic          s0_ARREADY,
    output logic          s0_RVALID,
    output logic [DW-1:0] s0_RDATA,
    output logic [1:0]    s0_RRESP,
    output logic          s0_RLAST,
    input  logic          s0_RREADY,
    input  logic          s1_ARVALID,
    input  logic [AW-1:0] s1_ARADDR,
    input  logic [7:0]    s1_ARLEN,
    output logic          s1_ARREADY,
    output logic          s1_RVALID,
    output logic [DW-1:0] s1_RDATA,
    output logic [1:0]    s1_RRESP,
    output logic          s1_RLAST,
    input  logic          s1_RREADY,
    input  logic          s2_ARVALID,
    input  logic [AW-1:0] s2_ARADDR,
    input  logic [7:0]    s2_ARLEN,
    output logic          s2_ARREADY,
    output logic          s2_RVALID,
    output logic [DW-1:0] s2_RDATA,
    output logic [1:0]    s2_RRESP,
    output logic          s2_RLAST,
    input  logic          s2_RREADY,
    input  logic          s3_ARVALID,
    input  logic [AW-1:0] s3_ARADDR,
    input  logic [7:0]    s3_ARLEN,
    output logic          s3_ARREADY,
    output logic          s3_RVALID,
    output logic [DW-1:0] s3_RDATA,
    output logic [1:0]    s3_RRESP,
    output logic          s3_RLAST,
    input  logic          s3_RREADY,
    output logic          m_ARVALID,
    output logic [AW-1:0] m_ARADDR,
    output logic [7:0]    m_ARLEN,
    input  logic          m_ARREADY,
    input  logic          m_RVALID,
    input  logic [DW-1:0] m_RDATA,
    input  logic [1:0]    m_RRESP,
    input  logic          m_RLAST,
    output logic          m_RREADY,
    output logic          rd_busy,
    output logic          rlast_err
);

    localparam int unsigned NM = 4;
    localparam int unsigned LW = 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_owner;
    logic [LW-1:0] r_cnt;
    logic [AW-1:0] r_araddr;
    logic [LW-1:0] r_arlen;
    beat_t         r_fifo [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          r_rlast_err;

    logic [NM-1:0] w_grnt;
    logic [NM-1:0] w_arvalid;
    logic [NM-1:0] w_rready;
    logic [AW-1:0] w_araddr [NM];
    logic [LW-1:0] w_arlen  [NM];
    logic [1:0]    w_sel;
    logic          w_sel_vld;
    logic [NM-1:0] w_arready;
    logic [NM-1:0] w_rvalid;
    logic          w_ar_take;
    logic          w_ar_hs;
    logic          w_m_arvalid;
    logic          w_m_rready;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_clr;
    logic          w_cnt_zero;
    beat_t         w_head;

    assign w_grnt    = {s3_rgrnt, s2_rgrnt, s1_rgrnt, s0_rgrnt};
    assign w_arvalid = {s3_ARVALID, s2_ARVALID, s1_ARVALID, s0_ARVALID};
    assign w_rready  = {s3_RREADY, s2_RREADY, s1_RREADY, s0_RREADY};
    assign w_araddr[0] = s0_ARADDR;
    assign w_araddr[1] = s1_ARADDR;
    assign w_araddr[2] = s2_ARADDR;
    assign w_araddr[3] = s3_ARADDR;
    assign w_arlen[0]  = s0_ARLEN;
    assign w_arlen[1]  = s1_ARLEN;
    assign w_arlen[2]  = s2_ARLEN;
    assign w_arlen[3]  = s3_ARLEN;

    // Lowest-numbered granted master wins.
    always_comb begin
        w_sel     = 2'd0;
        w_sel_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (w_grnt[i]) begin
                w_sel     = 2'(i);
                w_sel_vld = 1'b1;
            end
        end
    end

    assign w_head     = r_fifo[r_rptr];
    assign w_cnt_zero = (r_cnt == '0);
    assign w_push     = w_m_rready & m_RVALID;
    assign w_fifo_clr = w_pop & w_head.last;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arready   = '0;
        w_rvalid    = '0;
        w_ar_take   = 1'b0;
        w_ar_hs     = 1'b0;
        w_m_arvalid = 1'b0;
        w_m_rready  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_vld) begin
                    w_arready[w_sel] = 1'b1;
                    if (w_arvalid[w_sel]) begin
                        w_ar_take   = 1'b1;
                        w_state_nxt = ADDR;
                    end
                end
            end
            ADDR: begin
                w_m_arvalid = 1'b1;
                if (m_ARREADY) begin
                    w_ar_hs     = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_m_rready = (r_count != 2'd2);
                if (r_count != 2'd0) begin
                    w_rvalid[r_owner] = 1'b1;
                    if (w_rready[r_owner]) begin
                        w_pop = 1'b1;
                        if (w_head.last) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // AR capture, beat counter, length checker and R FIFO.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_owner     <= 2'd0;
            r_cnt       <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_rlast_err <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_ar_take) begin
                r_owner  <= w_sel;
                r_araddr <= w_araddr[w_sel];
                r_arlen  <= w_arlen[w_sel];
            end
            if (w_ar_hs) begin
                r_cnt <= r_arlen;
            end else if (w_push && !w_cnt_zero) begin
                r_cnt <= r_cnt - LW'(1);
            end
            r_rlast_err <= w_push & (m_RLAST ^ w_cnt_zero);
            if (w_push) begin
                r_fifo[r_wptr] <= '{data: m_RDATA, resp: m_RRESP, last: m_RLAST};
            end
            if (w_fifo_clr) begin
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wptr <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                r_count <= r_count + 2'(w_push) - 2'(w_pop);
            end
        end
    end

    assign m_ARVALID = w_m_arvalid;
    assign m_ARADDR  = r_araddr;
    assign m_ARLEN   = r_arlen;
    assign m_RREADY  = w_m_rready;
    assign rd_busy   = (r_state != IDLE);
    assign rlast_err = r_rlast_err;

    assign s0_ARREADY = w_arready[0];
    assign s1_ARREADY = w_arready[1];
    assign s2_ARREADY = w_arready[2];
    assign s3_ARREADY = w_arready[3];

    // Only the owner sees the FIFO head; everyone else reads zeros.
    assign s0_RVALID = w_rvalid[0];
    assign s0_RDATA  = w_rvalid[0] ? w_head.data : '0;
    assign s0_RRESP  = w_rvalid[0] ? w_head.resp : 2'd0;
    assign s0_RLAST  = w_rvalid[0] & w_head.last;
    assign s1_RVALID = w_rvalid[1];
    assign s1_RDATA  = w_rvalid[1] ? w_head.data : '0;
    assign s1_RRESP  = w_rvalid[1] ? w_head.resp : 2'd0;
    assign s1_RLAST  = w_rvalid[1] & w_head.last;
    assign s2_RVALID = w_rvalid[2];
    assign s2_RDATA  = w_rvalid[2] ? w_head.data : '0;
    assign s2_RRESP  = w_rvalid[2] ? w_head.resp : 2'd0;
    assign s2_RLAST  = w_rvalid[2] & w_head.last;
    assign s3_RVALID = w_rvalid[3];
    assign s3_RDATA  = w_rvalid[3] ? w_head.data : '0;
    assign s3_RRESP  = w_rvalid[3] ? w_head.resp : 2'd0;
    assign s3_RLAST  = w_rvalid[3] & w_head.last;

endmodule

// File: tb/tb_axi_mux_r.sv
// Scoreboard bench for axi_mux_r: slave beats queue expectations, a monitor checks master-side delivery.
module tb_axi_mux_r;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  rgrnt = '0;
    logic [3:0]  arvalid = '0;
    logic [3:0]  rready = 4'hF;
    logic [31:0] araddr [4];
    logic [7:0]  arlen  [4];
    logic [3:0]  arready;
    logic [3:0]  rvalid;
    logic [3:0]  rlast;
    logic [31:0] rdata [4];
    logic [1:0]  rresp [4];
    logic        m_ARVALID;
    logic [31:0] m_ARADDR;
    logic [7:0]  m_ARLEN;
    logic        m_ARREADY = 1'b0;
    logic        m_RVALID = 1'b0;
    logic [31:0] m_RDATA = '0;
    logic [1:0]  m_RRESP = '0;
    logic        m_RLAST = 1'b0;
    logic        m_RREADY;
    logic        rd_busy;
    logic        rlast_err;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   mon_nv;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_seen = 0;
    int   err0;
    logic exp_err = 1'b0;
    logic ok;

    always #5 ACLK = ~ACLK;

    axi_mux_r #(.AW(32), .DW(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s0_rgrnt(rgrnt[0]), .s1_rgrnt(rgrnt[1]), .s2_rgrnt(rgrnt[2]), .s3_rgrnt(rgrnt[3]),
        .s0_ARVALID(arvalid[0]), .s0_ARADDR(araddr[0]), .s0_ARLEN(arlen[0]), .s0_ARREADY(arready[0]),
        .s0_RVALID(rvalid[0]), .s0_RDATA(rdata[0]), .s0_RRESP(rresp[0]), .s0_RLAST(rlast[0]), .s0_RREADY(rready[0]),
        .s1_ARVALID(arvalid[1]), .s1_ARADDR(araddr[1]), .s1_ARLEN(arlen[1]), .s1_ARREADY(arready[1]),
        .s1_RVALID(rvalid[1]), .s1_RDATA(rdata[1]), .s1_RRESP(rresp[1]), .s1_RLAST(rlast[1]), .s1_RREADY(rready[1]),
        .s2_ARVALID(arvalid[2]), .s2_ARADDR(araddr[2]), .s2_ARLEN(arlen[2]), .s2_ARREADY(arready[2]),
        .s2_RVALID(rvalid[2]), .s2_RDATA(rdata[2]), .s2_RRESP(rresp[2]), .s2_RLAST(rlast[2]), .s2_RREADY(rready[2]),
        .s3_ARVALID(arvalid[3]), .s3_ARADDR(araddr[3]), .s3_ARLEN(arlen[3]), .s3_ARREADY(arready[3]),
        .s3_RVALID(rvalid[3]), .s3_RDATA(rdata[3]), .s3_RRESP(rresp[3]), .s3_RLAST(rlast[3]), .s3_RREADY(rready[3]),
        .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARREADY(m_ARREADY),
        .m_RVALID(m_RVALID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST), .m_RREADY(m_RREADY),
        .rd_busy(rd_busy), .rlast_err(rlast_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected clean completion", name);
    endtask

    function automatic logic [31:0] pat(input int o, input int b);
        return 32'hA000_0000 | (32'(o) << 16) | 32'(b);
    endfunction

    // Master-side monitor: pop and compare on every owner handshake.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            mon_nv = 0;
            for (int i = 0; i < 4; i++) begin
                if (rvalid[i]) mon_nv++;
                if (rvalid[i] && rready[i]) begin
                    if (sb.size() == 0) begin
                        fail_evt("unexpected_beat");
                    end else begin
                        mon_e = sb.pop_front();
                        check("beat_owner", 64'(i), 64'(mon_e.owner));
                        check("beat_data", 64'(rdata[i]), 64'(mon_e.data));
                        check("beat_resp_last", 64'({rresp[i], rlast[i]}), 64'({mon_e.resp, mon_e.last}));
                    end
                end
            end
            if (mon_nv > 1) fail_evt("multiple_rvalid");
            check("rlast_err", 64'(rlast_err), 64'(exp_err));
            if (rlast_err) err_seen++;
        end
    end

    task automatic raise_ar(input int n, input logic [31:0] addr, input logic [7:0] len);
        rgrnt[n]   = 1'b1;
        arvalid[n] = 1'b1;
        araddr[n]  = addr;
        arlen[n]   = len;
    endtask

    task automatic wait_ar(input int n, input int other);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge ACLK);
            if (arready[n]) begin
                got = 1'b1;
                if (other >= 0) check("other_arready_low", 64'(arready[other]), 64'd0);
                break;
            end
        end
        if (!got) fail_evt("ar_accept_timeout");
        @(posedge ACLK); #1;
        rgrnt[n]   = 1'b0;
        arvalid[n] = 1'b0;
    endtask

    // Slave model: accept AR after ar_delay stall cycles, then stream nbeats with RLAST on the final one.
    task automatic slave_serve(input int owner, input logic [31:0] addr, input logic [7:0] len,
                               input int nbeats, input int ar_delay);
        logic got;
        logic hs;
        logic lst;
        int   b;
        int   cnt;
        exp_t e;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge ACLK);
            if (m_ARVALID) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_evt("m_arvalid_timeout");
        check("m_araddr", 64'(m_ARADDR), 64'(addr));
        check("m_arlen", 64'(m_ARLEN), 64'(len));
        for (int d = 0; d < ar_delay; d++) begin
            @(negedge ACLK);
            check("m_arvalid_hold", 64'(m_ARVALID), 64'd1);
            check("m_araddr_hold", 64'(m_ARADDR), 64'(addr));
            check("m_arlen_hold", 64'(m_ARLEN), 64'(len));
        end
        @(posedge ACLK); #1;
        m_ARREADY = 1'b1;
        @(posedge ACLK); #1;
        m_ARREADY = 1'b0;
        b = 0;
        for (int c = 0; c < 200 && b < nbeats; c++) begin
            lst      = (b == nbeats - 1);
            m_RVALID = 1'b1;
            m_RDATA  = pat(owner, b);
            m_RRESP  = 2'(b);
            m_RLAST  = lst;
            cnt      = (int'(len) > b) ? int'(len) - b : 0;
            @(negedge ACLK);
            hs = m_RREADY;
            if (hs) begin
                e.owner = owner;
                e.data  = pat(owner, b);
                e.resp  = 2'(b);
                e.last  = lst;
                sb.push_back(e);
            end
            @(posedge ACLK); #1;
            exp_err = hs && (lst != (cnt == 0));
            if (hs) b++;
        end
        m_RVALID = 1'b0;
        m_RLAST  = 1'b0;
        if (b != nbeats) fail_evt("slave_beats_timeout");
        @(posedge ACLK); #1;
        exp_err = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            @(negedge ACLK);
            if (!rd_busy && sb.size() == 0) break;
        end
        check("rd_busy_idle", 64'(rd_busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected test end");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            araddr[i] = '0;
            arlen[i]  = '0;
        end
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_busy", 64'(rd_busy), 64'd0);
        check("rst_m_arvalid", 64'(m_ARVALID), 64'd0);
        check("rst_m_rready", 64'(m_RREADY), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast_err", 64'(rlast_err), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // Basic 4-beat burst to s1.
        err0 = err_seen;
        @(posedge ACLK); #1;
        raise_ar(1, 32'h0000_1000, 8'd3);
        wait_ar(1, -1);
        slave_serve(1, 32'h0000_1000, 8'd3, 4, 0);
        wait_idle();
        check("t1_no_err", 64'(err_seen - err0), 64'd0);

        // Grant moves to s0 while s2 owns a burst.
        @(posedge ACLK); #1;
        raise_ar(2, 32'h0000_2200, 8'd1);
        wait_ar(2, -1);
        fork
            slave_serve(2, 32'h0000_2200, 8'd1, 2, 0);
            begin
                repeat (2) @(posedge ACLK);
                #1;
                raise_ar(0, 32'h0000_0300, 8'd0);
                ok = 1'b0;
                for (int c = 0; c < 60; c++) begin
                    @(negedge ACLK);
                    if (rd_busy) begin
                        check("s0_arready_blocked", 64'(arready[0]), 64'd0);
                    end else begin
                        check("s0_arready_after", 64'(arready[0]), 64'd1);
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) fail_evt("s0_accept_timeout");
                @(posedge ACLK); #1;
                rgrnt[0]   = 1'b0;
                arvalid[0] = 1'b0;
            end
        join
        slave_serve(0, 32'h0000_0300, 8'd0, 1, 0);
        wait_idle();

        // s3 stalls RREADY for 5 cycles mid-burst.
        @(posedge ACLK); #1;
        raise_ar(3, 32'h0000_3000, 8'd7);
        wait_ar(3, -1);
        fork
            slave_serve(3, 32'h0000_3000, 8'd7, 8, 0);
            begin
                ok = 1'b0;
                for (int c = 0; c < 60; c++) begin
                    @(negedge ACLK);
                    if (rvalid[3]) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) fail_evt("s3_rvalid_timeout");
                @(posedge ACLK); #1;
                rready[3] = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge ACLK);
                    if (k == 4) begin
                        check("stall_m_rready", 64'(m_RREADY), 64'd0);
                        check("stall_s3_rvalid", 64'(rvalid[3]), 64'd1);
                    end
                    @(posedge ACLK); #1;
                end
                rready[3] = 1'b1;
            end
        join
        wait_idle();

        // Early RLAST: LEN=2 but slave ends after 2 beats.
        err0 = err_seen;
        @(posedge ACLK); #1;
        raise_ar(0, 32'h0000_0400, 8'd2);
        wait_ar(0, -1);
        slave_serve(0, 32'h0000_0400, 8'd2, 2, 0);
        wait_idle();
        check("t4_err_pulses", 64'(err_seen - err0), 64'd1);

        // Slave holds ARREADY low.
        @(posedge ACLK); #1;
        raise_ar(1, 32'h0000_1500, 8'd1);
        wait_ar(1, -1);
        slave_serve(1, 32'h0000_1500, 8'd1, 2, 4);
        wait_idle();

        // Simultaneous grants: s0 wins, s2 follows once idle.
        @(posedge ACLK); #1;
        raise_ar(0, 32'h0000_0600, 8'd0);
        raise_ar(2, 32'h0000_2600, 8'd1);
        wait_ar(0, 2);
        slave_serve(0, 32'h0000_0600, 8'd0, 1, 0);
        wait_ar(2, -1);
        slave_serve(2, 32'h0000_2600, 8'd1, 2, 0);
        wait_idle();

        // Reset during DATA with a full FIFO.
        @(posedge ACLK); #1;
        rready[2] = 1'b0;
        raise_ar(2, 32'h0000_2400, 8'd7);
        wait_ar(2, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (m_ARVALID) break;
        end
        @(posedge ACLK); #1;
        m_ARREADY = 1'b1;
        @(posedge ACLK); #1;
        m_ARREADY = 1'b0;
        m_RVALID  = 1'b1;
        m_RDATA   = 32'hDEAD_0000;
        m_RLAST   = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("pre_rst_s2_rvalid", 64'(rvalid[2]), 64'd1);
        check("pre_rst_m_rready", 64'(m_RREADY), 64'd0);
        @(posedge ACLK); #2;
        ARESETn = 1'b0;
        #1;
        check("mid_rst_busy", 64'(rd_busy), 64'd0);
        check("mid_rst_m_arvalid", 64'(m_ARVALID), 64'd0);
        check("mid_rst_m_rready", 64'(m_RREADY), 64'd0);
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_rlast_err", 64'(rlast_err), 64'd0);
        m_RVALID  = 1'b0;
        rready[2] = 1'b1;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge ACLK);
            check("post_rst_rvalid", 64'(rvalid), 64'd0);
            check("post_rst_busy", 64'(rd_busy), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
